noc_vc_output_mux: RTL and testbench

// Downstream stage of the per-VC input flit FIFO in a LOCAL/INTERNAL router port.
// - Accepts up to CHANNELS FIFO heads; picks one per cycle by round-robin.
// - Drives a single registered flit link, VC-tagged by a one-hot valid.
// - Flow control is credit-based against the next hop's per-VC FIFO (depth CREDITS).
// - Checks per-VC head/tail framing and flags violations.

---
 rtl/noc_vc_output_mux.sv | 165 ++++++++++++++++
 tb/tb_noc_vc_output_mux.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_output_mux.sv
// noc_vc_output_mux
// Output stage behind the per-VC input flit FIFOs of a local/internal router port.
// It picks one FIFO head per cycle by round-robin and drives a single registered,
// VC-tagged flit link. Flow control is credit-based against the next hop's per-VC
// FIFO, and per-VC head/tail framing is checked on every forwarded flit.
//
// Ports
//   noc_clk          clock, all logic on the rising edge
//   noc_rst          synchronous active-high reset
//   i_clear          synchronous soft clear, same effect as noc_rst
//   i_vc_valid       FIFO head valid per VC
//   i_vc_flit        FIFO head flits, VC c at bits [c*FLIT_WIDTH +: FLIT_WIDTH]
//   o_vc_pop         one-hot pop to the FIFOs (combinational grant)
//   o_valid          registered one-hot link valid, doubles as the VC tag
//   o_flit           registered link flit
//   i_credit_return  one-cycle pulse per flit freed downstream, per VC
//   o_credit_avail   per-VC credit count is non-zero
//   o_error          sticky framing / credit-overflow error
module noc_vc_output_mux #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FLIT_WIDTH = 34,
    parameter int unsigned CREDITS    = 8
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst,
    input  logic                           i_clear,
    input  logic [CHANNELS-1:0]            i_vc_valid,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] i_vc_flit,
    output logic [CHANNELS-1:0]            o_vc_pop,
    output logic [CHANNELS-1:0]            o_valid,
    output logic [FLIT_WIDTH-1:0]          o_flit,
    input  logic [CHANNELS-1:0]            i_credit_return,
    output logic [CHANNELS-1:0]            o_credit_avail,
    output logic                           o_error
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);
    localparam logic [PW-1:0] LAST_VC    = PW'(CHANNELS - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } vc_state_t;

    // Per-VC state
    logic [CW-1:0]         credit   [CHANNELS];
    vc_state_t             vc_state [CHANNELS];
    logic [PW-1:0]         rr_ptr;

    // Arbitration / datapath
    logic [FLIT_WIDTH-1:0] flit_arr [CHANNELS];
    logic [CHANNELS-1:0]   eligible;
    int unsigned           cand_w;
    logic [PW-1:0]         cand;
    logic                  grant_valid;
    logic [PW-1:0]         grant_idx;
    logic [FLIT_WIDTH-1:0] grant_flit;
    logic                  grant_head;
    logic                  grant_tail;
    logic                  frame_err;
    logic                  credit_err;

    // Unpack the flat head-flit bus and derive per-VC eligibility
    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        assign flit_arr[c]       = i_vc_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
        assign o_credit_avail[c] = (credit[c] != '0);
        assign eligible[c]       = i_vc_valid[c] && (credit[c] != '0);
    end

    // Round-robin search: first eligible VC at or after rr_ptr, wrapping around
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_w      = 0;
        cand        = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand_w = 32'(rr_ptr) + k;
            if (cand_w >= CHANNELS) begin
                cand_w = cand_w - CHANNELS;
            end
            cand = PW'(cand_w);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot pop straight from the grant so the FIFO advances this cycle
    always_comb begin
        o_vc_pop = '0;
        if (grant_valid) begin
            o_vc_pop[grant_idx] = 1'b1;
        end
    end

    assign grant_flit = flit_arr[grant_idx];
    assign grant_head = grant_flit[FLIT_WIDTH-1];
    assign grant_tail = grant_flit[FLIT_WIDTH-2];

    // Framing violation: body/tail with no open packet, or head inside a packet
    always_comb begin
        frame_err = 1'b0;
        if (grant_valid) begin
            if (vc_state[grant_idx] == ST_IDLE) begin
                frame_err = !grant_head;
            end else begin
                frame_err = grant_head;
            end
        end
    end

    // Credit return with no matching grant while already full is an overflow
    always_comb begin
        credit_err = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (i_credit_return[c] && !o_vc_pop[c] && (credit[c] == CREDIT_MAX)) begin
                credit_err = 1'b1;
            end
        end
    end

    // Link register, round-robin pointer, credits and framing state
    always_ff @(posedge noc_clk) begin
        if (noc_rst || i_clear) begin
            o_valid <= '0;
            o_flit  <= '0;
            o_error <= 1'b0;
            rr_ptr  <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                credit[c]   <= CREDIT_MAX;
                vc_state[c] <= ST_IDLE;
            end
        end else begin
            o_valid <= o_vc_pop;

            if (grant_valid) begin
                o_flit <= grant_flit;
                rr_ptr <= (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
                // Illegal flits still resync the state on their tail bit
                vc_state[grant_idx] <= grant_tail ? ST_IDLE : ST_IN_PKT;
            end

            // Grant and return in the same cycle cancel out
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                case ({o_vc_pop[c], i_credit_return[c]})
                    2'b10: credit[c] <= credit[c] - 1'b1;
                    2'b01: begin
                        if (credit[c] != CREDIT_MAX) begin
                            credit[c] <= credit[c] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (frame_err || credit_err) begin
                o_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_vc_output_mux.sv
module tb_noc_vc_output_mux;

    localparam int unsigned CH = 2;
    localparam int unsigned FW = 34;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic [CH-1:0]     vc_valid;
    logic [CH*FW-1:0]  vc_flit;
    logic [CH-1:0]     credit_return;
    logic [CH-1:0]     vc_pop;
    logic [CH-1:0]     link_valid;
    logic [FW-1:0]     link_flit;
    logic [CH-1:0]     credit_avail;
    logic              err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noc_vc_output_mux #(.CHANNELS(CH), .FLIT_WIDTH(FW), .CREDITS(8)) dut (
        .noc_clk         (clk),
        .noc_rst         (rst),
        .i_clear         (clr),
        .i_vc_valid      (vc_valid),
        .i_vc_flit       (vc_flit),
        .o_vc_pop        (vc_pop),
        .o_valid         (link_valid),
        .o_flit          (link_flit),
        .i_credit_return (credit_return),
        .o_credit_avail  (credit_avail),
        .o_error         (err)
    );

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [31:0] d);
        return {h, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; vc_valid = '0; vc_flit = '0; credit_return = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (link_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", link_valid); end
        total++; if (link_flit !== '0) begin bad++; $display("FAIL reset_flit got=%h want=0", link_flit); end
        total++; if (credit_avail !== 2'b11) begin bad++; $display("FAIL reset_avail got=%b want=11", credit_avail); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", err); end
        total++; if (vc_pop !== 2'b00) begin bad++; $display("FAIL reset_pop got=%b want=00", vc_pop); end
    endtask

    task automatic test_credit_exhaust();
        logic [CH-1:0] exp;
        logic [FW-1:0] f;
        do_reset();
        vc_valid = 2'b01;
        for (int k = 0; k < 12; k++) begin
            f = mk(1'b1, 1'b1, 32'h100 + 32'(k));
            vc_flit = {{FW{1'b0}}, f};
            exp = (k < 8) ? 2'b01 : 2'b00;
            #1;
            total++; if (vc_pop !== exp) begin bad++; $display("FAIL exhaust_pop k=%0d got=%b want=%b", k, vc_pop, exp); end
            tick();
            total++; if (link_valid !== exp) begin bad++; $display("FAIL exhaust_valid k=%0d got=%b want=%b", k, link_valid, exp); end
            if (k < 8) begin
                total++; if (link_flit !== f) begin bad++; $display("FAIL exhaust_flit k=%0d got=%h want=%h", k, link_flit, f); end
            end
        end
        total++; if (credit_avail !== 2'b10) begin bad++; $display("FAIL exhaust_avail got=%b want=10", credit_avail); end
        // one return pulse buys exactly one more pop
        credit_return = 2'b01;
        #1;
        total++; if (vc_pop !== 2'b00) begin bad++; $display("FAIL return_cycle_pop got=%b want=00", vc_pop); end
        tick();
        credit_return = 2'b00;
        #1;
        total++; if (vc_pop !== 2'b01) begin bad++; $display("FAIL return_pop got=%b want=01", vc_pop); end
        tick();
        total++; if (link_valid !== 2'b01) begin bad++; $display("FAIL return_valid got=%b want=01", link_valid); end
        total++; if (vc_pop !== 2'b00) begin bad++; $display("FAIL return_stall got=%b want=00", vc_pop); end
        total++; if (credit_avail !== 2'b10) begin bad++; $display("FAIL return_avail got=%b want=10", credit_avail); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL exhaust_error got=%b want=0", err); end
    endtask

    task automatic test_rr();
        logic [CH-1:0] exp;
        logic [FW-1:0] f0, f1, last;
        do_reset();
        // only VC1 valid with pointer at 0: wraps to VC1
        f0 = mk(1'b1, 1'b1, 32'h1FF);
        f1 = mk(1'b1, 1'b1, 32'h2FF);
        vc_flit = {f1, f0};
        vc_valid = 2'b10;
        #1;
        total++; if (vc_pop !== 2'b10) begin bad++; $display("FAIL rr_wrap_pop got=%b want=10", vc_pop); end
        tick();
        total++; if (link_valid !== 2'b10) begin bad++; $display("FAIL rr_wrap_valid got=%b want=10", link_valid); end
        vc_valid = 2'b11;
        last = '0;
        for (int k = 0; k < 6; k++) begin
            f0 = mk(1'b1, 1'b1, 32'h200 + 32'(k));
            f1 = mk(1'b1, 1'b1, 32'h300 + 32'(k));
            vc_flit = {f1, f0};
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            last = (k % 2 == 0) ? f0 : f1;
            #1;
            total++; if (vc_pop !== exp) begin bad++; $display("FAIL rr_pop k=%0d got=%b want=%b", k, vc_pop, exp); end
            tick();
            total++; if (link_valid !== exp) begin bad++; $display("FAIL rr_valid k=%0d got=%b want=%b", k, link_valid, exp); end
            total++; if (link_flit !== last) begin bad++; $display("FAIL rr_flit k=%0d got=%h want=%h", k, link_flit, last); end
        end
        vc_valid = 2'b00;
        #1;
        total++; if (vc_pop !== 2'b00) begin bad++; $display("FAIL idle_pop got=%b want=00", vc_pop); end
        tick();
        total++; if (link_valid !== 2'b00) begin bad++; $display("FAIL idle_valid got=%b want=00", link_valid); end
        total++; if (link_flit !== last) begin bad++; $display("FAIL idle_flit_hold got=%h want=%h", link_flit, last); end
    endtask

    task automatic test_simultaneous();
        logic [CH-1:0] exp;
        do_reset();
        vc_valid = 2'b01;
        vc_flit = {{FW{1'b0}}, mk(1'b1, 1'b1, 32'h777)};
        #1;
        total++; if (vc_pop !== 2'b01) begin bad++; $display("FAIL simul_first_pop got=%b want=01", vc_pop); end
        tick();
        // grant plus return each cycle: count stays at 7
        credit_return = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (vc_pop !== 2'b01) begin bad++; $display("FAIL simul_pop k=%0d got=%b want=01", k, vc_pop); end
            tick();
        end
        credit_return = 2'b00;
        for (int k = 0; k < 10; k++) begin
            exp = (k < 7) ? 2'b01 : 2'b00;
            #1;
            total++; if (vc_pop !== exp) begin bad++; $display("FAIL simul_drain k=%0d got=%b want=%b", k, vc_pop, exp); end
            tick();
        end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL simul_error got=%b want=0", err); end
        // return while full: error, count stays 8
        do_reset();
        credit_return = 2'b01;
        tick();
        credit_return = 2'b00;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL overflow_error got=%b want=1", err); end
        vc_valid = 2'b01;
        vc_flit = {{FW{1'b0}}, mk(1'b1, 1'b1, 32'h888)};
        for (int k = 0; k < 10; k++) begin
            exp = (k < 8) ? 2'b01 : 2'b00;
            #1;
            total++; if (vc_pop !== exp) begin bad++; $display("FAIL overflow_drain k=%0d got=%b want=%b", k, vc_pop, exp); end
            tick();
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b want=1", err); end
    endtask

    task automatic test_framing();
        logic [1:0] ht [5];
        logic [FW-1:0] f;
        logic exp_err;
        ht[0] = 2'b10; ht[1] = 2'b00; ht[2] = 2'b01; ht[3] = 2'b10; ht[4] = 2'b10;
        do_reset();
        vc_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            f = mk(ht[i][1], ht[i][0], 32'h400 + 32'(i));
            vc_flit = {f, {FW{1'b0}}};
            exp_err = (i == 4);
            #1;
            total++; if (vc_pop !== 2'b10) begin bad++; $display("FAIL frame_pop i=%0d got=%b want=10", i, vc_pop); end
            tick();
            total++; if (link_valid !== 2'b10) begin bad++; $display("FAIL frame_valid i=%0d got=%b want=10", i, link_valid); end
            total++; if (link_flit !== f) begin bad++; $display("FAIL frame_flit i=%0d got=%h want=%h", i, link_flit, f); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL frame_error i=%0d got=%b want=%b", i, err, exp_err); end
        end
    endtask

    task automatic test_clear();
        logic [CH-1:0] exp;
        do_reset();
        vc_valid = 2'b01;
        vc_flit = {{FW{1'b0}}, mk(1'b1, 1'b0, 32'h500)};
        #1;
        total++; if (vc_pop !== 2'b01) begin bad++; $display("FAIL clear_head_pop got=%b want=01", vc_pop); end
        tick();
        total++; if (link_valid !== 2'b01) begin bad++; $display("FAIL clear_head_valid got=%b want=01", link_valid); end
        vc_valid = 2'b00;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (link_valid !== 2'b00) begin bad++; $display("FAIL clear_valid got=%b want=00", link_valid); end
        total++; if (link_flit !== '0) begin bad++; $display("FAIL clear_flit got=%h want=0", link_flit); end
        total++; if (credit_avail !== 2'b11) begin bad++; $display("FAIL clear_avail got=%b want=11", credit_avail); end
        vc_valid = 2'b01;
        vc_flit = {{FW{1'b0}}, mk(1'b1, 1'b0, 32'h501)};
        #1;
        total++; if (vc_pop !== 2'b01) begin bad++; $display("FAIL clear_newhead_pop got=%b want=01", vc_pop); end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL clear_newhead_error got=%b want=0", err); end
        vc_flit = {{FW{1'b0}}, mk(1'b0, 1'b0, 32'h502)};
        for (int k = 0; k < 10; k++) begin
            exp = (k < 7) ? 2'b01 : 2'b00;
            #1;
            total++; if (vc_pop !== exp) begin bad++; $display("FAIL clear_credit k=%0d got=%b want=%b", k, vc_pop, exp); end
            tick();
        end
        total++; if (credit_avail !== 2'b10) begin bad++; $display("FAIL clear_final_avail got=%b want=10", credit_avail); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL clear_final_error got=%b want=0", err); end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; vc_valid = '0; vc_flit = '0; credit_return = '0;
        test_reset();
        test_credit_exhaust();
        test_rr();
        test_simultaneous();
        test_framing();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
